// File: rtl/sm_arbiter_if.sv
// sm_arbiter_if: per-core request/completion bundle plus shared-memory port.
// master = arbiter side, slave = cores and memory side.
interface sm_arbiter_if #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8
);
    logic [N_CORES-1:0]        core_req;
    logic [N_CORES-1:0]        core_we;
    logic [N_CORES*ADDR_W-1:0] core_addr;
    logic [N_CORES*DATA_W-1:0] core_wdata;
    logic [N_CORES-1:0]        core_val;
    logic [DATA_W-1:0]         core_rdata;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      busy;
    logic [3:0]                grant_id;

    modport master (
        input  core_req, core_we, core_addr, core_wdata, mem_rdata,
        output core_val, core_rdata, mem_en, mem_we, mem_addr,
        output mem_wdata, busy, grant_id
    );

    modport slave (
        output core_req, core_we, core_addr, core_wdata, mem_rdata,
        input  core_val, core_rdata, mem_en, mem_we, mem_addr,
        input  mem_wdata, busy, grant_id
    );
endinterface

// File: rtl/sm_arbiter.sv
// sm_arbiter: round-robin arbiter giving N GPU cores serialized access
// to one shared memory; every output is a register.
module sm_arbiter #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8
) (
    input logic          clk,
    input logic          reset,
    sm_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RELEASE
    } state_t;

    state_t              state, state_n;
    logic [N_CORES-1:0]  val_q, val_n;
    logic [DATA_W-1:0]   rdata_q, rdata_n;
    logic                en_q, en_n;
    logic                we_q, we_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic [DATA_W-1:0]   wdata_q, wdata_n;
    logic                busy_q, busy_n;
    logic [3:0]          gid_q, gid_n;
    logic [3:0]          last_q, last_n;

    logic                found;
    logic [3:0]          win;
    logic                we_sel;
    logic [ADDR_W-1:0]   addr_sel;
    logic [DATA_W-1:0]   wdata_sel;
    logic                req_g;

    // Round-robin pick: scan from last_grant+1 with wrap, first requester wins.
    always_comb begin
        found     = 1'b0;
        win       = '0;
        we_sel    = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        for (int i = 1; i <= N_CORES; i++) begin
            for (int c = 0; c < N_CORES; c++) begin
                if (!found && bus.core_req[c] &&
                    ((int'(last_q) + i) % N_CORES) == c) begin
                    found     = 1'b1;
                    win       = 4'(c);
                    we_sel    = bus.core_we[c];
                    addr_sel  = bus.core_addr[c*ADDR_W +: ADDR_W];
                    wdata_sel = bus.core_wdata[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Request level of the core currently holding the grant.
    always_comb begin
        req_g = 1'b0;
        for (int c = 0; c < N_CORES; c++) begin
            if (gid_q == 4'(c) && bus.core_req[c]) begin
                req_g = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_n = state;
        val_n   = '0;
        rdata_n = rdata_q;
        en_n    = 1'b0;
        we_n    = we_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        gid_n   = gid_q;
        last_n  = last_q;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = ISSUE;
                    en_n    = 1'b1;
                    gid_n   = win;
                    we_n    = we_sel;
                    addr_n  = addr_sel;
                    wdata_n = wdata_sel;
                end
            end
            ISSUE: begin
                state_n = WAIT;
            end
            WAIT: begin
                if (!we_q) begin
                    rdata_n = bus.mem_rdata;
                end
                for (int c = 0; c < N_CORES; c++) begin
                    val_n[c] = (gid_q == 4'(c));
                end
                state_n = RELEASE;
            end
            RELEASE: begin
                if (!req_g) begin
                    last_n  = gid_q;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            val_q   <= '0;
            rdata_q <= '0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            gid_q   <= '0;
            last_q  <= 4'(N_CORES - 1);
        end else begin
            state   <= state_n;
            val_q   <= val_n;
            rdata_q <= rdata_n;
            en_q    <= en_n;
            we_q    <= we_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            busy_q  <= busy_n;
            gid_q   <= gid_n;
            last_q  <= last_n;
        end
    end

    assign bus.core_val   = val_q;
    assign bus.core_rdata = rdata_q;
    assign bus.mem_en     = en_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.busy       = busy_q;
    assign bus.grant_id   = gid_q;

endmodule

// File: tb/tb_sm_arbiter.sv
// tb_sm_arbiter: directed scenarios plus randomized core traffic,
// checked every cycle against a transaction-level reference model.
module tb_sm_arbiter;
    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sm_arbiter_if #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sm_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks;
    int n_fail;

    logic [N-1:0]  req_r;
    logic [N-1:0]  we_r;
    logic [AW-1:0] addr_r [N];
    logic [DW-1:0] wdata_r [N];
    logic          rst_drv;
    bit            rand_on;
    bit            got_val [N];
    bit            await_val [N];
    bit            granted [N];
    int            hold_left [N];
    int            hold_cfg [N];
    int            skips [N];

    logic [DW-1:0] env_mem [4096];
    logic [DW-1:0] m_mem [4096];

    bit            seen_en;
    bit            seen_we;
    logic [AW-1:0] seen_addr;
    logic [DW-1:0] seen_wdata;

    bit            m_active;
    bit            m_we;
    int            m_t;
    int            m_w;
    int            m_last;
    logic [3:0]    m_gid;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_ld;
    logic [DW-1:0] m_rdata;
    int            cyc;
    int            grants [$];
    int            n_en;
    int            n_busy;
    int            last_val_cyc;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_cores();
        req_r = '0;
        we_r  = '0;
        for (int c = 0; c < N; c++) begin
            addr_r[c]    = '0;
            wdata_r[c]   = '0;
            got_val[c]   = 0;
            await_val[c] = 0;
            granted[c]   = 0;
            hold_left[c] = 0;
            hold_cfg[c]  = 0;
        end
    endtask

    task automatic set_req(int c, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
        req_r[c]   = 1'b1;
        we_r[c]    = we;
        addr_r[c]  = a;
        wdata_r[c] = d;
    endtask

    // Inputs for the coming cycle: memory response, then core behaviour.
    task automatic drive();
        reset = rst_drv;
        if (seen_en && seen_we) env_mem[seen_addr] = seen_wdata;
        if (seen_en && !seen_we) bus.mem_rdata = env_mem[seen_addr];
        else bus.mem_rdata = DW'($urandom);
        for (int c = 0; c < N; c++) begin
            if (req_r[c]) begin
                if (got_val[c]) begin
                    if (hold_left[c] == 0) begin
                        req_r[c]   = 1'b0;
                        got_val[c] = 0;
                    end else begin
                        hold_left[c]--;
                    end
                end else if (rand_on && granted[c] && $urandom_range(0, 3) == 0) begin
                    req_r[c]     = 1'b0;
                    await_val[c] = 1;
                end
            end else if (rand_on && !await_val[c] && $urandom_range(0, 3) == 0) begin
                set_req(c, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                        DW'($urandom));
            end
        end
        bus.core_req = req_r;
        bus.core_we  = we_r;
        for (int c = 0; c < N; c++) begin
            bus.core_addr[c*AW +: AW]  = addr_r[c];
            bus.core_wdata[c*DW +: DW] = wdata_r[c];
        end
    endtask

    // Reference model: a grant taken in idle cycle t puts mem_en in t+1 and
    // core_val in t+3; service ends in the first cycle >= t+3 whose request
    // from the winner is low, and the following cycle is idle again.
    task automatic monitor();
        bit exp_en;
        bit fire;
        int w;
        cyc++;
        if (!reset) begin
            check("rst_val", bus.core_val, 0);
            check("rst_en", bus.mem_en, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_gid", bus.grant_id, 0);
            check("rst_rdata", bus.core_rdata, 0);
            check("rst_bus", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
            m_active = 0;
            m_last   = N - 1;
            m_gid    = '0;
            m_rdata  = '0;
            seen_en  = 0;
            for (int c = 0; c < N; c++) begin
                skips[c]     = 0;
                granted[c]   = 0;
                got_val[c]   = 0;
                await_val[c] = 0;
            end
            return;
        end
        if (bus.mem_en) n_en++;
        if (bus.busy) n_busy++;
        if (bus.core_val != 0) last_val_cyc = cyc;
        exp_en = m_active && (cyc == m_t + 1);
        fire   = m_active && (cyc == m_t + 3);
        if (fire && !m_we) m_rdata = m_ld;
        check("mem_en", bus.mem_en, exp_en);
        check("core_val", bus.core_val, fire ? (1 << m_w) : 0);
        check("busy", bus.busy, m_active);
        check("grant_id", bus.grant_id, m_gid);
        check("core_rdata", bus.core_rdata, m_rdata);
        if (exp_en) begin
            check("mem_we", bus.mem_we, m_we);
            check("mem_addr", bus.mem_addr, m_addr);
            check("mem_wdata", bus.mem_wdata, m_wdata);
        end
        seen_en    = bus.mem_en;
        seen_we    = bus.mem_we;
        seen_addr  = bus.mem_addr;
        seen_wdata = bus.mem_wdata;
        if (fire) begin
            granted[m_w] = 0;
            if (req_r[m_w]) begin
                got_val[m_w]   = 1;
                hold_left[m_w] = rand_on ? int'($urandom_range(0, 5)) : hold_cfg[m_w];
            end else begin
                await_val[m_w] = 0;
            end
        end
        if (m_active) begin
            if (cyc >= m_t + 3 && !req_r[m_w]) begin
                m_active = 0;
                m_last   = m_w;
            end
        end else if (req_r != 0) begin
            w = 0;
            for (int i = 1; i <= N; i++) begin
                if (req_r[(m_last + i) % N]) begin
                    w = (m_last + i) % N;
                    break;
                end
            end
            for (int c = 0; c < N; c++) begin
                if (req_r[c] && c != w) skips[c]++;
            end
            check("no_starve", skips[w] <= N - 1, 1);
            skips[w] = 0;
            m_active = 1;
            m_t      = cyc;
            m_w      = w;
            m_gid    = 4'(w);
            m_we     = we_r[w];
            m_addr   = addr_r[w];
            m_wdata  = wdata_r[w];
            if (m_we) m_mem[m_addr] = m_wdata;
            else m_ld = m_mem[m_addr];
            granted[w] = 1;
            grants.push_back(w);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        monitor();
    endtask

    task automatic run_idle(int limit);
        int k;
        k = 0;
        while ((req_r != 0 || m_active) && k < limit) begin
            step();
            k++;
        end
        check("idle_timeout", (req_r == 0) && !m_active, 1);
    endtask

    int t0;
    int e0;
    int b0;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        n_en     = 0;
        n_busy   = 0;
        rand_on  = 0;
        seen_en  = 0;
        m_active = 0;
        m_last   = N - 1;
        m_gid    = '0;
        m_rdata  = '0;
        last_val_cyc = 0;
        for (int i = 0; i < 4096; i++) begin
            env_mem[i] = DW'(i * 7 + 3);
            m_mem[i]   = DW'(i * 7 + 3);
        end
        clear_cores();
        bus.core_req   = '0;
        bus.core_we    = '0;
        bus.core_addr  = '0;
        bus.core_wdata = '0;
        bus.mem_rdata  = '0;
        rst_drv = 1'b0;
        reset   = 1'b1;
        #1 reset = 1'b0;
        repeat (3) step();

        // single load from core 2
        env_mem[12'h3A5] = 8'h5C;
        m_mem[12'h3A5]   = 8'h5C;
        grants.delete();
        rst_drv = 1'b1;
        set_req(2, 1'b0, 12'h3A5, 8'h00);
        step();
        t0 = cyc;
        run_idle(50);
        check("d_load_lat", last_val_cyc - t0, 3);
        check("d_load_rdata", bus.core_rdata, 8'h5C);
        check("d_load_gnt", grants[0], 2);

        // single store from core 1
        set_req(1, 1'b1, 12'h010, 8'hAB);
        step();
        run_idle(50);
        check("d_store_rdata", bus.core_rdata, 8'h5C);
        check("d_store_mem", env_mem[12'h010], 8'hAB);

        // contention after reset
        rst_drv = 1'b0;
        clear_cores();
        repeat (2) step();
        rst_drv = 1'b1;
        grants.delete();
        e0 = n_en;
        for (int c = 0; c < N; c++) set_req(c, 1'b0, AW'(c + 32), 8'h00);
        step();
        run_idle(100);
        check("d_cont_n", grants.size(), 4);
        for (int i = 0; i < 4; i++) check("d_cont_order", grants[i], i);
        check("d_cont_en", n_en - e0, 4);

        // wrap-around from last_grant = 3
        grants.delete();
        set_req(0, 1'b0, 12'h001, 8'h00);
        set_req(3, 1'b1, 12'h002, 8'h77);
        step();
        run_idle(100);
        check("d_wrap_0", grants[0], 0);
        check("d_wrap_1", grants[1], 3);

        // sticky request held 5 cycles after core_val
        hold_cfg[0] = 5;
        e0 = n_en;
        b0 = n_busy;
        set_req(0, 1'b0, 12'h003, 8'h00);
        step();
        run_idle(100);
        check("d_sticky_en", n_en - e0, 1);
        check("d_sticky_busy", n_busy - b0, 9);
        hold_cfg[0] = 0;

        // reset during WAIT
        set_req(2, 1'b0, 12'h005, 8'h00);
        repeat (3) step();
        rst_drv = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("d_rst_val", bus.core_val, 0);
        check("d_rst_en", bus.mem_en, 0);
        check("d_rst_busy", bus.busy, 0);
        check("d_rst_bus", {bus.grant_id, bus.mem_addr, bus.core_rdata}, 0);
        clear_cores();
        repeat (2) step();
        rst_drv = 1'b1;
        grants.delete();
        set_req(1, 1'b0, 12'h006, 8'h00);
        set_req(0, 1'b0, 12'h007, 8'h00);
        step();
        run_idle(100);
        check("d_rst_first", grants[0], 0);
        check("d_rst_second", grants[1], 1);

        // randomized traffic
        rand_on = 1;
        repeat (1500) step();
        rand_on = 0;
        run_idle(300);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
